// File: rtl/mm_io_trap_ctrl.sv
// ---------------------------------------------------------------------------
// mm_io_trap_ctrl
//
// Z80 I/O trap controller for the Nabu MegaMapper CPLD. It sits between the
// CPU bus and the system I/O decode.
//  - Writes to port groups selected by a 16-bit group mask are hidden from the
//    system (IORQ suppressed). Each such write has its port address and data
//    captured.
//  - An NMI pulse then lets the mapper supervisor emulate the access.
//  - The trap re-arms once the supervisor acknowledges it.
//  - An 8-port control window at CTRL_PORT is decoded here and never forwarded
//    to the system bus.
//
// Optional feature macro: MM_TRAP_READ_EN
//   Defined   : reads of masked groups are trapped too. The CPU sees 8'hFF
//               (open bus). The capture records cap_dir = 1 and
//               cap_data = 8'hFF.
//   Undefined : reads of masked groups pass through untouched and cap_dir is
//               always 0.
//
// Parameters:
//   CTRL_PORT  - base of the 8-port control window (low 3 bits must be 0)
//   NMI_CYCLES - width of the nmi_n low pulse in clk cycles (1..15)
//
// Ports:
//   clk        in   Z80 CPU clock; all bus inputs are synchronous to it
//   reset      in   asynchronous, active-high reset
//   addr       in   Z80 A[7:0]
//   data_in    in   Z80 data bus, input side
//   data_out   out  data driven to the CPU
//   data_oe    out  high = drive data_out onto the bus
//   wr_n       in   Z80 WR
//   rd_n       in   Z80 RD
//   iorq_n     in   Z80 IORQ
//   m1_n       in   Z80 M1
//   iorq_sys_n out  gated IORQ to the system decode
//   nmi_n      out  NMI to the CPU, active low
//   trap_busy  out  high while a trap is being signalled or serviced
//
// Control window (offset from CTRL_PORT):
//   +0 mask_lo (r/w)
//   +1 mask_hi (r/w)
//   +2 captured addr (r), any write = ack
//   +3 captured data (r)
//   +4 status {trap_busy, cap_dir, 6'b0} (r)
//   +5..+7 read 8'hFF, writes ignored
// ---------------------------------------------------------------------------
module mm_io_trap_ctrl #(
  parameter logic [7:0]  CTRL_PORT  = 8'h40,
  parameter int unsigned NMI_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       iorq_n,
  input  logic       m1_n,
  output logic       iorq_sys_n,
  output logic       nmi_n,
  output logic       trap_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    PULSE   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam logic [3:0] NMI_LOAD = 4'(NMI_CYCLES);

  // State and registers
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mask_lo_q, mask_lo_d;
  logic [7:0]  mask_hi_q, mask_hi_d;
  logic [7:0]  cap_addr_q, cap_addr_d;
  logic [7:0]  cap_data_q, cap_data_d;
  logic        cap_dir_q, cap_dir_d;
  logic        wr_n_prev_q, wr_n_prev_d;
  logic        nmi_n_q, nmi_n_d;
  logic        trap_busy_q, trap_busy_d;

  // Combinational decode
  logic        io_s;
  logic        ctrl_hit_s;
  logic [15:0] mask_s;
  logic        grp_hit_s;
  logic        acc_s;
  logic        trap_cond_s;
  logic        hold_sup_s;
  logic        rd_trap_s;
  logic        wr_fall_s;
  logic        ctrl_wr_s;
  logic        ack_s;
  logic [7:0]  data_out_s;
  logic        data_oe_s;

`ifdef MM_TRAP_READ_EN
  assign acc_s = !wr_n || !rd_n;
`else
  assign acc_s = !wr_n;
`endif

  // Bus decode: I/O cycle qualification, control window hit, trap condition.
  always_comb begin
    io_s        = !iorq_n && m1_n;
    ctrl_hit_s  = io_s && (addr[7:3] == CTRL_PORT[7:3]);
    mask_s      = {mask_hi_q, mask_lo_q};
    grp_hit_s   = io_s && !ctrl_hit_s && mask_s[addr[7:4]] && (state_q == IDLE);
    trap_cond_s = grp_hit_s && acc_s;
    // Once the trap has been taken, the FSM has left IDLE but the trapped bus
    // cycle is still running. Keep it hidden from the system until IORQ rises.
    hold_sup_s  = (state_q == HOLD) && !iorq_n;
    wr_fall_s   = !wr_n && wr_n_prev_q;
    ctrl_wr_s   = ctrl_hit_s && wr_fall_s;
    ack_s       = ctrl_wr_s && (addr[2:0] == 3'd2) && (state_q == SERVICE);
  end

`ifdef MM_TRAP_READ_EN
  // A trapped read keeps returning open bus for the rest of its bus cycle.
  assign rd_trap_s = !rd_n && (trap_cond_s || (hold_sup_s && cap_dir_q));
`else
  assign rd_trap_s = 1'b0;
`endif

  assign iorq_sys_n = iorq_n | ctrl_hit_s | trap_cond_s | hold_sup_s;

  // Read data mux: control window reads, or open bus for a trapped read.
  always_comb begin
    data_oe_s  = 1'b0;
    data_out_s = 8'h00;
    if (ctrl_hit_s && !rd_n) begin
      data_oe_s = 1'b1;
      case (addr[2:0])
        3'd0:    data_out_s = mask_lo_q;
        3'd1:    data_out_s = mask_hi_q;
        3'd2:    data_out_s = cap_addr_q;
        3'd3:    data_out_s = cap_data_q;
        3'd4:    data_out_s = {trap_busy_q, cap_dir_q, 6'b000000};
        default: data_out_s = 8'hFF;
      endcase
    end else if (rd_trap_s) begin
      data_oe_s  = 1'b1;
      data_out_s = 8'hFF;
    end else begin
      data_oe_s  = 1'b0;
      data_out_s = 8'h00;
    end
  end

  assign data_oe  = data_oe_s;
  assign data_out = data_out_s;

  // Control register and capture next-state logic.
  always_comb begin
    mask_lo_d   = mask_lo_q;
    mask_hi_d   = mask_hi_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    cap_dir_d   = cap_dir_q;
    wr_n_prev_d = wr_n;
    if (ctrl_wr_s && (addr[2:0] == 3'd0)) begin
      mask_lo_d = data_in;
    end else if (ctrl_wr_s && (addr[2:0] == 3'd1)) begin
      mask_hi_d = data_in;
    end else begin
      mask_lo_d = mask_lo_q;
      mask_hi_d = mask_hi_q;
    end
    if (trap_cond_s) begin
      cap_addr_d = addr;
`ifdef MM_TRAP_READ_EN
      cap_dir_d  = !rd_n;
      cap_data_d = !rd_n ? 8'hFF : data_in;
`else
      cap_dir_d  = 1'b0;
      cap_data_d = data_in;
`endif
    end else begin
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      cap_dir_d  = cap_dir_q;
    end
  end

  // Trap FSM next-state logic and pulse counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trap_cond_s) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (iorq_n) begin
          state_d = PULSE;
          cnt_d   = NMI_LOAD;
        end else begin
          state_d = HOLD;
        end
      end
      PULSE: begin
        // The count of 1 is the last low cycle, so the pulse is NMI_CYCLES wide.
        if (cnt_q <= 4'd1) begin
          state_d = SERVICE;
          cnt_d   = 4'd0;
        end else begin
          state_d = PULSE;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      SERVICE: begin
        if (ack_s) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    nmi_n_d     = (state_d != PULSE);
    trap_busy_d = (state_d == PULSE) || (state_d == SERVICE);
  end

  // State, control and capture registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mask_lo_q   <= 8'h00;
      mask_hi_q   <= 8'h00;
      cap_addr_q  <= 8'h00;
      cap_data_q  <= 8'h00;
      cap_dir_q   <= 1'b0;
      wr_n_prev_q <= 1'b1;
      nmi_n_q     <= 1'b1;
      trap_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_lo_q   <= mask_lo_d;
      mask_hi_q   <= mask_hi_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      cap_dir_q   <= cap_dir_d;
      wr_n_prev_q <= wr_n_prev_d;
      nmi_n_q     <= nmi_n_d;
      trap_busy_q <= trap_busy_d;
    end
  end

  assign nmi_n     = nmi_n_q;
  assign trap_busy = trap_busy_q;

endmodule

// File: tb/tb_mm_io_trap_ctrl.sv
module tb_mm_io_trap_ctrl;

  localparam logic [7:0] CTRL = 8'h40;
  localparam int         NMI  = 4;
`ifdef MM_TRAP_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       wr_n;
  logic       rd_n;
  logic       iorq_n;
  logic       m1_n;
  logic       iorq_sys_n;
  logic       nmi_n;
  logic       trap_busy;

  int checks;
  int failures;

  // Reference model: abstract trap controller state.
  logic [15:0] m_mask;
  bit          m_busy;
  logic [7:0]  m_cap_addr;
  logic [7:0]  m_cap_data;
  bit          m_cap_dir;

  mm_io_trap_ctrl #(.CTRL_PORT(CTRL), .NMI_CYCLES(NMI)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .wr_n(wr_n), .rd_n(rd_n),
    .iorq_n(iorq_n), .m1_n(m1_n), .iorq_sys_n(iorq_sys_n),
    .nmi_n(nmi_n), .trap_busy(trap_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 3-clock I/O bus cycle and observe the gated IORQ and read data.
  task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d, input bit wr,
                           input bit ia, output int sys_low, output int oe_cnt,
                           output logic [7:0] rdata);
    sys_low = 0;
    oe_cnt  = 0;
    rdata   = 8'h00;
    @(negedge clk);
    addr    = a;
    data_in = d;
    iorq_n  = 1'b0;
    m1_n    = ia ? 1'b0 : 1'b1;
    wr_n    = (wr && !ia) ? 1'b0 : 1'b1;
    rd_n    = (wr || ia) ? 1'b1 : 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (iorq_sys_n === 1'b0) sys_low++;
      if (data_oe === 1'b1) begin
        oe_cnt++;
        rdata = data_out;
      end
      @(negedge clk);
    end
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  // Watch nmi_n for a fixed window after a bus cycle.
  task automatic observe_nmi(output int low_cnt, output int first_idx, output int last_idx);
    low_cnt   = 0;
    first_idx = -1;
    last_idx  = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (nmi_n === 1'b0) begin
        if (first_idx < 0) first_idx = i;
        last_idx = i;
        low_cnt++;
      end
    end
  endtask

  // Predict the outcome of one bus cycle from the trap rules and update the model.
  task automatic model_step(input logic [7:0] a, input logic [7:0] d, input bit wr,
                            input bit ia, output int e_sys_low, output bit e_oe,
                            output logic [7:0] e_rdata, output bit e_trap);
    e_sys_low = 3;
    e_oe      = 1'b0;
    e_rdata   = 8'h00;
    e_trap    = 1'b0;
    if (!ia && a[7:3] == CTRL[7:3]) begin
      e_sys_low = 0;
      if (wr) begin
        if (a[2:0] == 3'd0) m_mask[7:0] = d;
        else if (a[2:0] == 3'd1) m_mask[15:8] = d;
        else if (a[2:0] == 3'd2) m_busy = 1'b0;
      end else begin
        e_oe = 1'b1;
        case (a[2:0])
          3'd0:    e_rdata = m_mask[7:0];
          3'd1:    e_rdata = m_mask[15:8];
          3'd2:    e_rdata = m_cap_addr;
          3'd3:    e_rdata = m_cap_data;
          3'd4:    e_rdata = {m_busy, m_cap_dir, 6'b000000};
          default: e_rdata = 8'hFF;
        endcase
      end
    end else if (!ia && m_mask[a[7:4]] && !m_busy && (wr || READ_EN)) begin
      e_sys_low  = 0;
      e_trap     = 1'b1;
      m_busy     = 1'b1;
      m_cap_addr = a;
      m_cap_dir  = !wr;
      m_cap_data = wr ? d : 8'hFF;
      e_oe       = !wr;
      e_rdata    = 8'hFF;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 8'h00; data_in = 8'h00;
    wr_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({nmi_n, trap_busy, data_oe, iorq_sys_n} !== 4'b1001) begin
      failures++;
      $display("FAIL reset_outputs: got nmi/busy/oe/sys=%b required 1001",
               {nmi_n, trap_busy, data_oe, iorq_sys_n});
    end
    checks++;
    if (data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_out: got %h required 00", data_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_transparent();
    int sl, oc, lc, fi, li;
    logic [7:0] rd;
    bus_cycle(8'h80, 8'h5A, 1'b1, 1'b0, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (sl !== 3) begin failures++; $display("FAIL transp_sys: got %0d low samples required 3", sl); end
    checks++;
    if (lc !== 0 || trap_busy !== 1'b0) begin
      failures++; $display("FAIL transp_nmi: got nmi_low=%0d busy=%b required 0 0", lc, trap_busy);
    end
  endtask

  task automatic test_trap_write();
    int sl, oc, lc, fi, li;
    logic [7:0] rd;
    bus_cycle(CTRL + 8'd1, 8'h01, 1'b1, 1'b0, sl, oc, rd);
    checks++;
    if (sl !== 0) begin failures++; $display("FAIL ctrl_not_forwarded: got %0d low samples required 0", sl); end
    bus_cycle(8'h85, 8'hA7, 1'b1, 1'b0, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (sl !== 0) begin failures++; $display("FAIL trap_sys_suppressed: got %0d low samples required 0", sl); end
    checks++;
    if (lc !== NMI || fi !== 0 || li !== NMI - 1) begin
      failures++; $display("FAIL trap_nmi_pulse: got len=%0d first=%0d last=%0d required %0d 0 %0d",
                           lc, fi, li, NMI, NMI - 1);
    end
    bus_cycle(CTRL + 8'd2, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (oc !== 3 || rd !== 8'h85) begin failures++; $display("FAIL cap_addr: got %h oe=%0d required 85 oe=3", rd, oc); end
    bus_cycle(CTRL + 8'd3, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'hA7) begin failures++; $display("FAIL cap_data: got %h required a7", rd); end
    bus_cycle(CTRL + 8'd4, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'h80) begin failures++; $display("FAIL status_write_trap: got %h required 80", rd); end
  endtask

  task automatic test_service();
    int sl, oc, lc, fi, li;
    logic [7:0] rd;
    bus_cycle(8'h86, 8'h11, 1'b1, 1'b0, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (sl !== 3 || lc !== 0) begin
      failures++; $display("FAIL service_pass: got sys_low=%0d nmi_low=%0d required 3 0", sl, lc);
    end
    bus_cycle(CTRL + 8'd2, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'h85) begin failures++; $display("FAIL service_no_recapture: got %h required 85", rd); end
    bus_cycle(CTRL + 8'd2, 8'h3C, 1'b1, 1'b0, sl, oc, rd);
    #1;
    checks++;
    if (trap_busy !== 1'b0) begin failures++; $display("FAIL ack_clears_busy: got %b required 0", trap_busy); end
    bus_cycle(8'h86, 8'h22, 1'b1, 1'b0, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (sl !== 0 || lc !== NMI) begin
      failures++; $display("FAIL rearm_trap: got sys_low=%0d nmi_low=%0d required 0 %0d", sl, lc, NMI);
    end
    bus_cycle(CTRL + 8'd3, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'h22) begin failures++; $display("FAIL rearm_cap_data: got %h required 22", rd); end
    bus_cycle(CTRL + 8'd2, 8'h00, 1'b1, 1'b0, sl, oc, rd);
  endtask

  task automatic test_intack();
    int sl, oc, lc, fi, li;
    logic [7:0] rd;
    bus_cycle(8'h85, 8'h99, 1'b0, 1'b1, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (sl !== 3 || oc !== 0 || lc !== 0 || trap_busy !== 1'b0) begin
      failures++; $display("FAIL intack_ignored: got sys_low=%0d oe=%0d nmi_low=%0d busy=%b required 3 0 0 0",
                           sl, oc, lc, trap_busy);
    end
  endtask

  task automatic test_read_trap();
    int sl, oc, lc, fi, li;
    logic [7:0] rd;
    bus_cycle(CTRL, 8'h10, 1'b1, 1'b0, sl, oc, rd);
    bus_cycle(8'h4A, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    observe_nmi(lc, fi, li);
    checks++;
    if (READ_EN) begin
      if (sl !== 0 || oc !== 3 || rd !== 8'hFF || lc !== NMI) begin
        failures++; $display("FAIL read_trap: got sys_low=%0d oe=%0d data=%h nmi_low=%0d required 0 3 ff %0d",
                             sl, oc, rd, lc, NMI);
      end
    end else begin
      if (sl !== 3 || oc !== 0 || lc !== 0) begin
        failures++; $display("FAIL read_pass: got sys_low=%0d oe=%0d nmi_low=%0d required 3 0 0", sl, oc, lc);
      end
    end
    bus_cycle(CTRL + 8'd4, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== (READ_EN ? 8'hC0 : 8'h00)) begin
      failures++; $display("FAIL read_status: got %h required %h", rd, READ_EN ? 8'hC0 : 8'h00);
    end
    bus_cycle(CTRL + 8'd2, 8'h00, 1'b1, 1'b0, sl, oc, rd);
    bus_cycle(CTRL, 8'h00, 1'b1, 1'b0, sl, oc, rd);
  endtask

  task automatic test_reset_mid_pulse();
    int sl, oc;
    logic [7:0] rd;
    bus_cycle(CTRL + 8'd1, 8'h01, 1'b1, 1'b0, sl, oc, rd);
    bus_cycle(8'h85, 8'h44, 1'b1, 1'b0, sl, oc, rd);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (nmi_n !== 1'b0) begin failures++; $display("FAIL pulse_active: got nmi_n=%b required 0", nmi_n); end
    reset = 1'b1;
    #1;
    checks++;
    if (nmi_n !== 1'b1 || trap_busy !== 1'b0) begin
      failures++; $display("FAIL async_reset: got nmi_n=%b busy=%b required 1 0", nmi_n, trap_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_cycle(CTRL, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'h00) begin failures++; $display("FAIL reset_mask_lo: got %h required 00", rd); end
    bus_cycle(CTRL + 8'd1, 8'h00, 1'b0, 1'b0, sl, oc, rd);
    checks++;
    if (rd !== 8'h00) begin failures++; $display("FAIL reset_mask_hi: got %h required 00", rd); end
  endtask

  task automatic test_random();
    int sl, oc, lc, fi, li, es;
    bit eoe, etrap, wr, ia;
    logic [7:0] rd, erd, a, d;
    int r;
    m_mask = 16'h0000; m_busy = 1'b0; m_cap_addr = 8'h00; m_cap_data = 8'h00; m_cap_dir = 1'b0;
    for (int n = 0; n < 120; n++) begin
      r  = int'($urandom_range(0, 9));
      ia = 1'b0;
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (r < 4) begin
        a = CTRL | 8'($urandom_range(0, 7));
        d = 8'($urandom) & 8'($urandom);
      end else if (r < 9) begin
        a = 8'($urandom);
      end else begin
        a  = 8'($urandom);
        ia = 1'b1;
        wr = 1'b0;
      end
      model_step(a, d, wr, ia, es, eoe, erd, etrap);
      bus_cycle(a, d, wr, ia, sl, oc, rd);
      observe_nmi(lc, fi, li);
      checks++;
      if (sl !== es) begin failures++; $display("FAIL rand_sys[%0d] a=%h: got %0d required %0d", n, a, sl, es); end
      checks++;
      if (oc !== (eoe ? 3 : 0) || (eoe && rd !== erd)) begin
        failures++; $display("FAIL rand_read[%0d] a=%h: got oe=%0d data=%h required oe=%0d data=%h",
                             n, a, oc, rd, eoe ? 3 : 0, erd);
      end
      checks++;
      if (lc !== (etrap ? NMI : 0) || fi !== (etrap ? 0 : -1)) begin
        failures++; $display("FAIL rand_nmi[%0d] a=%h: got len=%0d first=%0d required %0d %0d",
                             n, a, lc, fi, etrap ? NMI : 0, etrap ? 0 : -1);
      end
      checks++;
      if (trap_busy !== m_busy) begin
        failures++; $display("FAIL rand_busy[%0d]: got %b required %b", n, trap_busy, m_busy);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_transparent();
    test_trap_write();
    test_service();
    test_intack();
    test_read_trap();
    test_reset_mid_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
